led_pwm_engine: RTL and testbench
=================================

// Module: led_pwm_engine
// PURPOSE
// Parametrised single-clock LED display controller: receives serial grey-scale data, stores it in a
// ping-pong frame buffer, and drives CH constant-current channels with GS_BITS-bit PWM, time-multiplexed over SCAN rows.
// Vsync-driven bank swap; two PWM modes (contiguous / bit-scrambled).
// Sits between the display data interface and the row/column driver pads.
// PARAMETERS
// CH       16  number of PWM output channels (>=2, power of 2)
// GS_BITS  16  grey-scale resolution; row period = 2**GS_BITS cycles; GS_BITS > log2(CH)
// SCAN     16  rows per frame (>=2, power of 2); bank depth = SCAN*CH words of GS_BITS
// PORTS
// GCK    in   1              sole clock, all logic on posedge
// rst    in   1              synchronous, active-high reset
// DAI    in   1              serial data, MSB first, sampled when DEN=1
// DEN    in   1              data enable
// Vsync  in   1              frame-ready strobe (rising edge significant)
// mode   in   1              0 contiguous PWM, 1 scrambled PWM
// OUT    out  CH             channel drive, bit c = channel c
// ROW    out  log2(SCAN)     currently displayed row
// FRAME  out  1              1-cycle pulse at cnt=0,row=0
// OVF    out  1              sticky: word received with write pointer full; cleared on swap/rst
// BEHAVIOUR
// - Reset: OUT=0, ROW=0, FRAME=0, OVF=0, cnt=0, bitcnt=0, wptr=0, disp_bank=0, valid=0, pend=0. RAM not reset.
// - Receive: per DEN=1 cycle shift DAI into sreg, bitcnt++; at bitcnt=GS_BITS-1 write word to write bank
//   (=~disp_bank) at wptr (row-major: row*CH+ch) next cycle, wptr++. DEN=0 clears bitcnt (partial word discarded).
//   wptr==SCAN*CH: word dropped, OVF=1; no wrap.
// - Vsync: rising edge (registered compare) sets pend. Edge while pend=1 is absorbed.
// - Scan: cnt (GS_BITS) increments every cycle; on wrap ROW++ mod SCAN.
// - Swap point: cycle with ROW=SCAN-1, cnt=0, pend=1: disp_bank flips, valid=1, pend=0, wptr=0, bitcnt=0, OVF=0.
//   Word completing that same cycle goes to the pre-swap write bank, then pointer resets.
//   Vsync edge on swap-point cycle is swapped immediately.
// - Line fetch: during cnt=0..CH-1 read disp_bank addr ((ROW+1)%SCAN)*CH+cnt; 1-cycle RAM latency,
//   data lands in shadow[cnt] at cnt+1. At cnt wrap shadow copies to line register; mode latched here too.
//   Row 0 of new frame is therefore fetched from new bank; row SCAN-1 shows old bank.
// - PWM: cmp = mode_l ? bitrev(cnt) : cnt; OUT[c] registered = valid & (cmp < line[c]). gs=0 never on,
//   gs=2**GS_BITS-1 off one cycle per row. OUT has 1-cycle latency from cnt.
// - Before first swap (valid=0) OUT=0 while scan still runs.
// - rst mid-frame: everything returns to reset state next cycle; pending words lost.
// STRUCTURE
// - Package led_pkg: mode enum (PWM_CONT, PWM_SCRAM), bitrev function, clog2 helpers.
// - Sub-module led_frame_bank: simple dual-port sync RAM (1 write, 1 read, read latency 1),
//   instantiated twice; top muxes read data by disp_bank and write enable by ~disp_bank.
// - Top holds receiver, Vsync edge/pend, scan counters, shadow/line registers, comparators.
// TESTING
// - Reset: assert rst 3 cycles mid-scan -> OUT=0, ROW=0, OVF=0, no FRAME until 2**GS_BITS*SCAN cycles later.
// - Full frame: stream 256 words (value=ch*4096) then Vsync -> after swap, row0 OUT[c] high exactly c*4096 cycles/row.
// - Scrambled: mode=1, ch0=0x8000 -> OUT[0] toggles each cycle (on at even cnt), total 32768 cycles/row.
// - Overflow: 257 words without Vsync -> OVF=1 at 257th, bank contents of first 256 unchanged; cleared at swap.
// - Partial word: DEN drops after 7 bits, then full word 0x00FF -> stored word is 0x00FF at wptr 0.
// - Swap timing: Vsync mid row 5 -> ROW 15 still old data, ROW 0 next frame shows new; Vsync at swap cycle -> swap same cycle.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED PWM engine: PWM mode encoding,
// bit reversal for the scrambled compare, and width helpers.
package led_pkg;

  typedef enum logic {
    PWM_CONT  = 1'b0,
    PWM_SCRAM = 1'b1
  } pwm_mode_e;

  // Width of a counter/index covering n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Reverse the low w bits of x (w <= 32); bits above w must be zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = {<<{x}};
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/led_frame_bank.sv
// One frame bank: simple dual-port synchronous RAM, one write and one read
// port, read data available the cycle after the address is presented.
module led_frame_bank #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents are only meaningful once written,
  // and a reset port here would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_pwm_engine.sv
// LED display controller: serial grey-scale receiver into a ping-pong frame
// buffer, Vsync-driven bank swap, row scan with line prefetch and per-channel PWM.
module led_pwm_engine
  import led_pkg::*;
#(
  parameter int CH      = 16,
  parameter int GS_BITS = 16,
  parameter int SCAN    = 16
) (
  input  logic                    GCK,
  input  logic                    rst,
  input  logic                    DAI,
  input  logic                    DEN,
  input  logic                    Vsync,
  input  logic                    mode,
  output logic [CH-1:0]           OUT,
  output logic [$clog2(SCAN)-1:0] ROW,
  output logic                    FRAME,
  output logic                    OVF
);

  localparam int RW    = clog2_min1(SCAN);
  localparam int CW    = clog2_min1(CH);
  localparam int BW    = clog2_min1(GS_BITS);
  localparam int DEPTH = SCAN * CH;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [GS_BITS-1:0] CNT_MAX   = '1;
  localparam logic [RW-1:0]      ROW_MAX   = RW'(SCAN - 1);
  localparam logic [BW-1:0]      BIT_LAST  = BW'(GS_BITS - 1);
  localparam logic [AW:0]        WPTR_FULL = (AW + 1)'(DEPTH);

  // Scan and control state
  logic [GS_BITS-1:0] cnt;
  logic [RW-1:0]      row;
  logic               frame;
  logic               ovf;
  logic [BW-1:0]      bitcnt;
  logic [AW:0]        wptr;
  logic               disp_bank;
  logic               valid;
  logic               pend;
  logic               vsync_q;
  logic               wr_en;
  logic [CH-1:0]      out;

  // Datapath state
  logic [GS_BITS-1:0] sreg;
  logic               wr_bank;
  logic [AW-1:0]      wr_addr;
  logic [GS_BITS-1:0] wr_data;
  logic [GS_BITS-1:0] shadow [CH];
  logic [GS_BITS-1:0] line   [CH];
  pwm_mode_e          mode_l;

  logic [GS_BITS-1:0] word;
  logic               word_done;
  logic               vs_rise;
  logic               swap;
  logic [RW-1:0]      next_row;
  logic [AW-1:0]      rd_addr;
  logic [GS_BITS-1:0] rd_data0, rd_data1, rd_data;
  logic               fetch_slot;
  logic [CW-1:0]      fetch_idx;
  logic [GS_BITS-1:0] cmp;

  assign word       = {sreg[GS_BITS-2:0], DAI};
  assign word_done  = DEN && (bitcnt == BIT_LAST);
  assign vs_rise    = Vsync && !vsync_q;
  assign swap       = (row == ROW_MAX) && (cnt == '0) && (pend || vs_rise);
  assign next_row   = row + RW'(1);

  // The line for the next row is prefetched at the start of the current row.
  assign rd_addr    = {next_row, cnt[CW-1:0]};
  assign rd_data    = disp_bank ? rd_data1 : rd_data0;
  assign fetch_slot = (cnt != '0) && (cnt <= GS_BITS'(CH));
  assign fetch_idx  = CW'(cnt - GS_BITS'(1));
  assign cmp        = (mode_l == PWM_SCRAM) ? GS_BITS'(bitrev(32'(cnt), GS_BITS)) : cnt;

  led_frame_bank #(.DW(GS_BITS), .DEPTH(DEPTH)) u_bank0 (
    .clk   (GCK),
    .we    (wr_en && !wr_bank),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data0)
  );

  led_frame_bank #(.DW(GS_BITS), .DEPTH(DEPTH)) u_bank1 (
    .clk   (GCK),
    .we    (wr_en && wr_bank),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data1)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge value of every other register, whatever the order.
  always_ff @(posedge GCK) begin
    if (rst) begin
      cnt       <= '0;
      row       <= '0;
      frame     <= 1'b0;
      ovf       <= 1'b0;
      bitcnt    <= '0;
      wptr      <= '0;
      disp_bank <= 1'b0;
      valid     <= 1'b0;
      pend      <= 1'b0;
      vsync_q   <= 1'b0;
      wr_en     <= 1'b0;
      out       <= '0;
    end else begin
      vsync_q <= Vsync;
      cnt     <= cnt + GS_BITS'(1);
      frame   <= (cnt == CNT_MAX) && (row == ROW_MAX);
      if (cnt == CNT_MAX) row <= next_row;

      wr_en <= 1'b0;
      if (!DEN) begin
        bitcnt <= '0;
      end else if (!word_done) begin
        bitcnt <= bitcnt + BW'(1);
      end else begin
        bitcnt <= '0;
        if (wptr == WPTR_FULL) begin
          ovf <= 1'b1;
        end else begin
          wr_en <= 1'b1;
          wptr  <= wptr + (AW + 1)'(1);
        end
      end

      // A word completing on the swap cycle is already queued for the old write bank.
      if (swap) begin
        disp_bank <= !disp_bank;
        valid     <= 1'b1;
        pend      <= 1'b0;
        wptr      <= '0;
        bitcnt    <= '0;
        ovf       <= 1'b0;
      end else if (vs_rise) begin
        pend <= 1'b1;
      end

      for (int c = 0; c < CH; c++) out[c] <= valid && (cmp < line[c]);
    end
  end

  always_ff @(posedge GCK) begin
    if (DEN) sreg <= word;
    if (word_done) begin
      wr_bank <= !disp_bank;
      wr_addr <= wptr[AW-1:0];
      wr_data <= word;
    end
    if (fetch_slot) shadow[fetch_idx] <= rd_data;
    if (cnt == CNT_MAX) begin
      line   <= shadow;
      mode_l <= pwm_mode_e'(mode);
    end
  end

  assign OUT   = out;
  assign ROW   = row;
  assign FRAME = frame;
  assign OVF   = ovf;

endmodule

// File: tb/tb_led_pwm_engine.sv
// Directed bench for led_pwm_engine on a scaled geometry (4 channels,
// 4-bit grey scale, 4 rows): 16-cycle rows, 64-cycle frames.
module tb_led_pwm_engine;

  localparam int CH       = 4;
  localparam int GS       = 4;
  localparam int SCAN     = 4;
  localparam int ROWLEN   = 1 << GS;
  localparam int FRAMELEN = ROWLEN * SCAN;
  localparam int SWAP_PH  = (SCAN - 1) * ROWLEN;

  logic          GCK   = 1'b0;
  logic          rst   = 1'b1;
  logic          DAI   = 1'b0;
  logic          DEN   = 1'b0;
  logic          Vsync = 1'b0;
  logic          mode  = 1'b0;
  logic [CH-1:0] OUT;
  logic [1:0]    ROW;
  logic          FRAME;
  logic          OVF;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int s;

  led_pwm_engine #(.CH(CH), .GS_BITS(GS), .SCAN(SCAN)) dut (
    .GCK   (GCK),
    .rst   (rst),
    .DAI   (DAI),
    .DEN   (DEN),
    .Vsync (Vsync),
    .mode  (mode),
    .OUT   (OUT),
    .ROW   (ROW),
    .FRAME (FRAME),
    .OVF   (OVF)
  );

  always #5 GCK = ~GCK;

  // Free-running scan position as seen by the bench: cnt = cyc % ROWLEN.
  always @(posedge GCK) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge GCK);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  function automatic int next_at(input int from, input int phase);
    int t = from;
    while (t % FRAMELEN != phase) t++;
    return t;
  endfunction

  // Frame 0: ch*4+row, frame 1: ch0=8 else row*4+ch, frame 2: row*4+ch+3.
  function automatic logic [GS-1:0] word_val(input int f, input int r, input int c);
    case (f)
      0:       return GS'(c * 4 + r);
      1:       return (c == 0) ? GS'(8) : GS'(r * 4 + c);
      default: return GS'(r * 4 + c + 3);
    endcase
  endfunction

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < GS; i++) if (((k >> i) & 1) != 0) r |= 1 << (GS - 1 - i);
    return r;
  endfunction

  task automatic send_word(input logic [GS-1:0] v);
    for (int b = GS - 1; b >= 0; b--) begin
      DEN = 1'b1;
      DAI = v[b];
      tick();
    end
  endtask

  task automatic send_frame(input int f);
    for (int r = 0; r < SCAN; r++)
      for (int c = 0; c < CH; c++) send_word(word_val(f, r, c));
    DEN = 1'b0;
  endtask

  // Entered in the cnt=0 cycle of row r; OUT lags the compare by one cycle.
  task automatic check_row(input int f, input int r, input bit scram);
    logic [CH-1:0] exp;
    int            cmpv;
    check($sformatf("row index f%0d r%0d", f, r), 32'(ROW), r);
    for (int k = 0; k < ROWLEN; k++) begin
      tick();
      cmpv = scram ? rev(k) : k;
      for (int c = 0; c < CH; c++) exp[c] = (cmpv < int'(word_val(f, r, c)));
      check($sformatf("out f%0d r%0d k%0d", f, r, k), 32'(OUT), 32'(exp));
    end
  endtask

  initial begin
    repeat (3) @(posedge GCK);
    #1;
    rst = 1'b0;
    check("reset OUT", 32'(OUT), 0);
    check("reset ROW", 32'(ROW), 0);
    check("reset FRAME", 32'(FRAME), 0);
    check("reset OVF", 32'(OVF), 0);

    // Full frame, Vsync in row 0, swap at the next row-3 cnt-0 cycle.
    send_frame(0);
    Vsync = 1'b1;
    tick();
    tick();
    Vsync = 1'b0;
    s = next_at(cyc, SWAP_PH);
    goto(s + ROWLEN);
    for (int r = 0; r < SCAN; r++) check_row(0, r, 1'b0);
    check("ovf clear after frame 0", 32'(OVF), 0);

    // Vsync mid row 1: row 3 still old frame, row 0 new frame in scrambled mode.
    send_frame(1);
    goto(next_at(cyc, ROWLEN + ROWLEN / 2));
    Vsync = 1'b1;
    tick();
    tick();
    Vsync = 1'b0;
    s = next_at(cyc, SWAP_PH);
    goto(s);
    mode = 1'b1;
    check_row(0, SCAN - 1, 1'b0);
    check_row(1, 0, 1'b1);
    mode = 1'b0;

    // Partial word discarded, then a full bank plus one overflowing word.
    for (int b = 0; b < GS - 1; b++) begin
      DEN = 1'b1;
      DAI = 1'b1;
      tick();
    end
    DEN = 1'b0;
    tick();
    send_frame(2);
    check("ovf with bank just full", 32'(OVF), 0);
    send_word(GS'(12));
    DEN = 1'b0;
    check("ovf on extra word", 32'(OVF), 1);

    // Vsync rising exactly on the swap cycle swaps immediately.
    s = next_at(cyc, SWAP_PH);
    goto(s);
    Vsync = 1'b1;
    check("ovf held before swap", 32'(OVF), 1);
    tick();
    check("ovf cleared at swap", 32'(OVF), 0);
    tick();
    Vsync = 1'b0;
    goto(s + ROWLEN);
    check_row(2, 0, 1'b0);
    check_row(2, 1, 1'b0);

    // Mid-scan reset with OVF set and display active.
    send_frame(0);
    send_word(GS'(5));
    DEN = 1'b0;
    check("ovf before reset", 32'(OVF), 1);
    goto(cyc + 5);
    rst = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
    check("mid reset OUT", 32'(OUT), 0);
    check("mid reset ROW", 32'(ROW), 0);
    check("mid reset OVF", 32'(OVF), 0);
    check("mid reset FRAME", 32'(FRAME), 0);
    for (int k = 1; k <= FRAMELEN; k++) begin
      tick();
      check($sformatf("frame pulse k%0d", k), 32'(FRAME), 32'(k == FRAMELEN));
      check($sformatf("out idle k%0d", k), 32'(OUT), 0);
      if (k == ROWLEN) check("row advance after reset", 32'(ROW), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
